core_ex_lsu_queue: RTL and testbench
====================================

CORE_EX_LSU_QUEUE -- requirements
Module: core_ex_lsu_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2: request queue entries, power of two, at least 2.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles spent in WAIT before abort, range 1..65535.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 valid_in / ready_in  input / output  1 / 1  upstream request handshake.
REQ-006 i_lsu_inst_bus  input  `CORE_LSU_INST_WIDTH  fields used: LOAD, STORE, SIZE (00 byte, 01 half, 10 word), USIGN.
REQ-007 i_mem_addr / i_write_data  input  `CORE_XLEN  byte address and store data (low bits significant).
REQ-008 valid_out / ready_out  output / input  1 / 1  downstream result handshake.
REQ-009 read_data  output  `CORE_XLEN  load result, aligned and sign- or zero-extended.
REQ-010 o_err  output  1  result is aborted (misalign or timeout).
REQ-011 biu_req_valid / biu_req_ready  output / input  1 / 1  bus request handshake.
REQ-012 biu_req_addr / biu_req_wdata  output  `CORE_XLEN  word-aligned address ([1:0]=0) and lane-shifted store data.
REQ-013 biu_req_wmask / biu_req_write  output  4 / 1  byte-lane mask and store flag.
REQ-014 biu_rsp_valid / biu_rsp_rdata  input  1 / `CORE_XLEN  bus response, one per accepted request, loads and stores alike.

Function
REQ-015 Queue: FIFO of {inst, addr, wdata}; ready_in = !full; no push while full even if a pop occurs in the same cycle; push on valid_in & ready_in.
REQ-016 The head entry SHALL stay in the queue until its result handshakes out (valid_out & ready_out).
REQ-017 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-018 IDLE, queue non-empty: a LOAD or STORE head -> REQ; any other head, or a misaligned head (see REQ-026) -> DONE.
REQ-019 REQ: biu_req_valid=1 with all request fields stable; biu_req_ready -> WAIT and the timer clears.
REQ-020 WAIT: biu_rsp_valid -> DONE, capturing rdata; timer == TIMEOUT with no response -> DONE with o_err=1.
REQ-021 biu_rsp_valid SHALL be ignored in every state other than WAIT.
REQ-022 DONE: valid_out=1; on ready_out, pop the queue -> IDLE; read_data and o_err are held stable while stalled.
REQ-023 Minimum latency: push at edge N, zero-wait bus -> valid_out high in the cycle after edge N+3; throughput is one access per 4 cycles.
REQ-024 Load extraction: lane = addr[1:0]; byte/half sign-extended unless USIGN; word passed through; non-load results give read_data=0.
REQ-025 Store: wmask = 0001/0011/1111 shifted left by addr[1:0]; wdata shifted left by 8*addr[1:0].
REQ-026 Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.

Reset
REQ-027 On rst_n low, the following SHALL clear asynchronously: queue empty, FSM IDLE, timer 0, valid_out=0, o_err=0, read_data=0, biu_req_valid=0; ready_in=1 after reset.
REQ-028 Reset mid-transaction SHALL abandon the outstanding bus request; a later response is ignored per REQ-021.

Configuration
REQ-029 With CORE_LSU_MISALIGN_EXCP_EN defined: a misaligned head skips the bus and completes with o_err=1 and read_data=0.
REQ-030 With CORE_LSU_MISALIGN_EXCP_EN undefined: address bits below the access size are forced to zero, the access is issued, and o_err is raised only on timeout.

Verification
REQ-031 Push load word at 0x100, bus returns 0xDEADBEEF next cycle -> valid_out=1 with read_data=0xDEADBEEF, o_err=0.
REQ-032 Load byte signed at 0x103, rdata=0x80000000 -> read_data=0xFFFFFF80; with USIGN set -> 0x00000080.
REQ-033 Store half at 0x102, data 0x1234 -> biu_req_wmask=1100, biu_req_wdata=0x12340000, biu_req_addr=0x100.
REQ-034 DEPTH=2, biu_req_ready held low, three pushes -> ready_in low after the second; third accepted only after the first pops.
REQ-035 TIMEOUT=4, no response -> o_err=1 in DONE; a response arriving afterwards produces no second result.
REQ-036 Word load at 0x101 with macro defined -> no biu_req_valid, o_err=1; with macro undefined -> request issued to 0x100.

Source files
------------

// File: rtl/core_ex_lsu_queue_if.sv
// ---------------------------------------------------------------------------
// core_ex_lsu_queue_if
//
// Purpose: bundles every handshake and bus signal of core_ex_lsu_queue.
// The signals fall into three groups:
//   - upstream requests  : valid_in, ready_in, i_lsu_inst_bus, i_mem_addr,
//                          i_write_data
//   - downstream results : valid_out, ready_out, read_data, o_err
//   - bus (BIU) side     : biu_req_valid, biu_req_ready, biu_req_addr,
//                          biu_req_wdata, biu_req_wmask, biu_req_write,
//                          biu_rsp_valid, biu_rsp_rdata
//
// Modports:
//   slave  - the queue itself (core_ex_lsu_queue)
//   master - the surrounding pipeline and bus (or a testbench)
//
// Widths come from `CORE_XLEN and `CORE_LSU_INST_WIDTH. Each has a default
// here, so the file also stands alone.
// ---------------------------------------------------------------------------
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_LSU_INST_WIDTH
`define CORE_LSU_INST_WIDTH 5
`endif

interface core_ex_lsu_queue_if;
    logic                            valid_in;
    logic                            ready_in;
    logic [`CORE_LSU_INST_WIDTH-1:0] i_lsu_inst_bus;
    logic [`CORE_XLEN-1:0]           i_mem_addr;
    logic [`CORE_XLEN-1:0]           i_write_data;

    logic                            valid_out;
    logic                            ready_out;
    logic [`CORE_XLEN-1:0]           read_data;
    logic                            o_err;

    logic                            biu_req_valid;
    logic                            biu_req_ready;
    logic [`CORE_XLEN-1:0]           biu_req_addr;
    logic [`CORE_XLEN-1:0]           biu_req_wdata;
    logic [3:0]                      biu_req_wmask;
    logic                            biu_req_write;
    logic                            biu_rsp_valid;
    logic [`CORE_XLEN-1:0]           biu_rsp_rdata;

    modport slave (
        input  valid_in, i_lsu_inst_bus, i_mem_addr, i_write_data,
        output ready_in,
        output valid_out, read_data, o_err,
        input  ready_out,
        output biu_req_valid, biu_req_addr, biu_req_wdata, biu_req_wmask, biu_req_write,
        input  biu_req_ready, biu_rsp_valid, biu_rsp_rdata
    );

    modport master (
        output valid_in, i_lsu_inst_bus, i_mem_addr, i_write_data,
        input  ready_in,
        input  valid_out, read_data, o_err,
        output ready_out,
        input  biu_req_valid, biu_req_addr, biu_req_wdata, biu_req_wmask, biu_req_write,
        output biu_req_ready, biu_rsp_valid, biu_rsp_rdata
    );
endinterface

// File: rtl/core_ex_lsu_queue.sv
// ---------------------------------------------------------------------------
// core_ex_lsu_queue
//
// Purpose: load/store request queue for the execute stage. Incoming accesses
// are buffered in a small FIFO. The head entry is issued to the bus interface
// unit (BIU) one at a time. When the response returns, the result is aligned
// and sign- or zero-extended, then handed downstream. The head entry leaves
// the FIFO only after its result has been accepted.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - core_ex_lsu_queue_if.slave (upstream, downstream and BIU signals)
//
// Parameters:
//   DEPTH   - queue entries (power of two, >= 2)
//   TIMEOUT - WAIT cycles counted (timer 0..TIMEOUT) before the access aborts
//
// Instruction bus layout (i_lsu_inst_bus):
//   [0] LOAD   [1] STORE   [3:2] SIZE (00 byte, 01 half, 10 word)   [4] USIGN
//
// Configuration macro: CORE_LSU_MISALIGN_EXCP_EN
//   defined   - a misaligned head bypasses the bus and completes with
//               o_err=1 and read_data=0
//   undefined - the low address bits are forced to the access size and the
//               access is issued; o_err is raised only on a bus timeout
// ---------------------------------------------------------------------------
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_LSU_INST_WIDTH
`define CORE_LSU_INST_WIDTH 5
`endif

module core_ex_lsu_queue #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    core_ex_lsu_queue_if.slave  bus
);

    localparam int XLEN = `CORE_XLEN;
    localparam int IW   = `CORE_LSU_INST_WIDTH;
    localparam int AW   = $clog2(DEPTH);

    localparam int INST_LOAD  = 0;
    localparam int INST_STORE = 1;
    localparam int INST_SIZE  = 2;
    localparam int INST_USIGN = 4;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Request FIFO
    // -----------------------------------------------------------------------
    logic [IW-1:0]   mem_inst  [DEPTH];
    logic [XLEN-1:0] mem_addr  [DEPTH];
    logic [XLEN-1:0] mem_wdata [DEPTH];

    // One extra pointer bit tells full from empty when the indices are equal.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign bus.ready_in = !full;
    // ready_in is taken from the registered full flag, so a pop in the same
    // cycle never opens a slot for a push while the queue is full.
    assign push         = bus.valid_in && !full;

    // NOTE: storage arrays have no reset. The pointers alone define which
    // entries are valid, and an unreset array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr_q[AW-1:0]]  <= bus.i_lsu_inst_bus;
            mem_addr[wr_ptr_q[AW-1:0]]  <= bus.i_mem_addr;
            mem_wdata[wr_ptr_q[AW-1:0]] <= bus.i_write_data;
        end
    end

    // NOTE: sequential state is always written with non-blocking (<=)
    // assignments, so every register samples its pre-edge inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // -----------------------------------------------------------------------
    // Head entry decode
    // -----------------------------------------------------------------------
    logic [IW-1:0]   head_inst;
    logic [XLEN-1:0] head_addr;
    logic [XLEN-1:0] head_wdata;
    logic            head_load;
    logic            head_store;
    logic            head_access;
    logic [1:0]      head_size;
    logic            head_usign;
    logic [1:0]      lane;
    logic [3:0]      mask_base;

    assign head_inst   = mem_inst[rd_ptr_q[AW-1:0]];
    assign head_addr   = mem_addr[rd_ptr_q[AW-1:0]];
    assign head_wdata  = mem_wdata[rd_ptr_q[AW-1:0]];
    assign head_load   = head_inst[INST_LOAD];
    assign head_store  = head_inst[INST_STORE] && !head_inst[INST_LOAD];
    assign head_access = head_inst[INST_LOAD] || head_inst[INST_STORE];
    assign head_size   = head_inst[INST_SIZE+1:INST_SIZE];
    assign head_usign  = head_inst[INST_USIGN];

`ifdef CORE_LSU_MISALIGN_EXCP_EN
    // SIZE 11 is treated as a word everywhere in this block.
    logic head_misalign;
    assign head_misalign = head_access &&
                           (((head_size == 2'b01) && head_addr[0]) ||
                            (head_size[1] && (head_addr[1:0] != 2'b00)));
`endif

    // The effective byte lane drops the address bits below the access size.
    // An aligned access is unaffected. A misaligned access reaches this path
    // only when misalign exceptions are disabled.
    always_comb begin
        lane = head_addr[1:0];
        if (head_size[1]) begin
            lane = 2'b00;
        end else if (head_size == 2'b01) begin
            lane[0] = 1'b0;
        end
    end

    always_comb begin
        case (head_size)
            2'b00:   mask_base = 4'b0001;
            2'b01:   mask_base = 4'b0011;
            default: mask_base = 4'b1111;
        endcase
    end

    // All request fields come from the head entry. That entry cannot change
    // until its result pops, so the fields hold steady for the whole REQ state.
    assign bus.biu_req_addr  = {head_addr[XLEN-1:2], 2'b00};
    assign bus.biu_req_wdata = head_wdata << {lane, 3'b000};
    assign bus.biu_req_wmask = mask_base << lane;
    assign bus.biu_req_write = head_store;

    // -----------------------------------------------------------------------
    // Load data extraction from the raw bus word
    // -----------------------------------------------------------------------
    logic [7:0]      rsp_byte;
    logic [15:0]     rsp_half;
    logic [XLEN-1:0] load_data;

    always_comb begin
        case (lane)
            2'd0:    rsp_byte = bus.biu_rsp_rdata[7:0];
            2'd1:    rsp_byte = bus.biu_rsp_rdata[15:8];
            2'd2:    rsp_byte = bus.biu_rsp_rdata[23:16];
            default: rsp_byte = bus.biu_rsp_rdata[31:24];
        endcase
    end

    assign rsp_half = lane[1] ? bus.biu_rsp_rdata[31:16] : bus.biu_rsp_rdata[15:0];

    always_comb begin
        case (head_size)
            2'b00:   load_data = head_usign ? {{(XLEN-8){1'b0}}, rsp_byte}
                                            : {{(XLEN-8){rsp_byte[7]}}, rsp_byte};
            2'b01:   load_data = head_usign ? {{(XLEN-16){1'b0}}, rsp_half}
                                            : {{(XLEN-16){rsp_half[15]}}, rsp_half};
            default: load_data = bus.biu_rsp_rdata;
        endcase
    end

    // -----------------------------------------------------------------------
    // Access FSM
    // -----------------------------------------------------------------------
    state_t          state_q;
    state_t          state_d;
    logic [15:0]     timer_q;
    logic [15:0]     timer_d;
    logic            res_we;
    logic [XLEN-1:0] res_data_d;
    logic            res_err_d;
    logic [XLEN-1:0] read_data_q;
    logic            err_q;

    // NOTE: every signal driven here is given a default first. A path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        res_we     = 1'b0;
        res_data_d = '0;
        res_err_d  = 1'b0;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
`ifdef CORE_LSU_MISALIGN_EXCP_EN
                    if (head_access && !head_misalign) begin
                        state_d = S_REQ;
                    end else begin
                        // Non-accesses and misaligned accesses complete
                        // without touching the bus.
                        state_d   = S_DONE;
                        res_we    = 1'b1;
                        res_err_d = head_misalign;
                    end
`else
                    if (head_access) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                        res_we  = 1'b1;
                    end
`endif
                end
            end

            S_REQ: begin
                if (bus.biu_req_ready) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end
            end

            S_WAIT: begin
                // A response takes priority over a timeout in the same cycle.
                if (bus.biu_rsp_valid) begin
                    state_d    = S_DONE;
                    res_we     = 1'b1;
                    res_data_d = head_load ? load_data : '0;
                end else if (timer_q == TIMEOUT_W) begin
                    state_d   = S_DONE;
                    res_we    = 1'b1;
                    res_err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            S_DONE: begin
                if (bus.ready_out) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            read_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            // The result registers load only when DONE is entered, so they
            // hold steady while the downstream side stalls.
            if (res_we) begin
                read_data_q <= res_data_d;
                err_q       <= res_err_d;
            end
        end
    end

    assign bus.biu_req_valid = (state_q == S_REQ);
    assign bus.valid_out     = (state_q == S_DONE);
    assign bus.read_data     = read_data_q;
    assign bus.o_err         = err_q;

endmodule

// File: tb/tb_core_ex_lsu_queue.sv
// ---------------------------------------------------------------------------
// tb_core_ex_lsu_queue
//
// Purpose: directed, self-checking bench for core_ex_lsu_queue with DEPTH=2
// and TIMEOUT=4. Every expected value below was worked out by hand from the
// cycle behaviour of the queue:
//   push at edge N -> REQ after N+1 -> WAIT after N+2 -> DONE after N+3
//   -> pop at N+4 when ready_out is high.
// Inputs are driven 1 ns after each rising edge and sampled at that same
// point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_core_ex_lsu_queue;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // inst encoding: [0] LOAD [1] STORE [3:2] SIZE [4] USIGN
    localparam logic [4:0] I_LW  = 5'b01001;
    localparam logic [4:0] I_LH  = 5'b00101;
    localparam logic [4:0] I_LB  = 5'b00001;
    localparam logic [4:0] I_LBU = 5'b10001;
    localparam logic [4:0] I_SH  = 5'b00110;
    localparam logic [4:0] I_NOP = 5'b00000;

    core_ex_lsu_queue_if bus_if ();

    core_ex_lsu_queue #(
        .DEPTH   (2),
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge. Returns 1 ns after that edge.
    task automatic push(input logic [4:0] inst, input logic [31:0] addr, input logic [31:0] wdata);
        bus_if.valid_in       = 1'b1;
        bus_if.i_lsu_inst_bus = inst;
        bus_if.i_mem_addr     = addr;
        bus_if.i_write_data   = wdata;
        cyc();
        bus_if.valid_in = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus_if.valid_in       = 1'b0;
        bus_if.i_lsu_inst_bus = '0;
        bus_if.i_mem_addr     = '0;
        bus_if.i_write_data   = '0;
        bus_if.ready_out      = 1'b1;
        bus_if.biu_req_ready  = 1'b1;
        bus_if.biu_rsp_valid  = 1'b0;
        bus_if.biu_rsp_rdata  = '0;

        // ---------------- reset state ----------------
        cyc();
        cyc();
        check("rst_ready_in",  32'(bus_if.ready_in), 32'd1);
        check("rst_valid_out", 32'(bus_if.valid_out), 32'd0);
        check("rst_err",       32'(bus_if.o_err), 32'd0);
        check("rst_read_data", bus_if.read_data, 32'h0);
        check("rst_req_valid", 32'(bus_if.biu_req_valid), 32'd0);
        rst_n = 1'b1;
        cyc();

        // ---------------- load word at 0x100 ----------------
        push(I_LW, 32'h100, 32'h0);
        check("lw_idle_no_req", 32'(bus_if.biu_req_valid), 32'd0);
        cyc();
        check("lw_req_valid", 32'(bus_if.biu_req_valid), 32'd1);
        check("lw_req_addr",  bus_if.biu_req_addr, 32'h100);
        check("lw_req_mask",  32'(bus_if.biu_req_wmask), 32'hF);
        check("lw_req_write", 32'(bus_if.biu_req_write), 32'd0);
        cyc();
        bus_if.biu_rsp_valid = 1'b1;
        bus_if.biu_rsp_rdata = 32'hDEADBEEF;
        check("lw_wait_no_out", 32'(bus_if.valid_out), 32'd0);
        cyc();
        bus_if.biu_rsp_valid = 1'b0;
        check("lw_valid_out", 32'(bus_if.valid_out), 32'd1);
        check("lw_read_data", bus_if.read_data, 32'hDEADBEEF);
        check("lw_err",       32'(bus_if.o_err), 32'd0);
        cyc();
        check("lw_popped", 32'(bus_if.valid_out), 32'd0);

        // ---------------- signed byte at 0x103, stalled downstream ----------------
        bus_if.ready_out = 1'b0;
        push(I_LB, 32'h103, 32'h0);
        cyc();
        check("lb_req_mask", 32'(bus_if.biu_req_wmask), 32'h8);
        check("lb_req_addr", bus_if.biu_req_addr, 32'h100);
        cyc();
        bus_if.biu_rsp_valid = 1'b1;
        bus_if.biu_rsp_rdata = 32'h80000000;
        cyc();
        bus_if.biu_rsp_valid = 1'b1;
        bus_if.biu_rsp_rdata = 32'h7F7F7F7F;
        check("lb_read_data", bus_if.read_data, 32'hFFFFFF80);
        cyc();
        // A stray response during DONE is ignored, and the result holds.
        check("lb_stall_valid", 32'(bus_if.valid_out), 32'd1);
        check("lb_stall_hold",  bus_if.read_data, 32'hFFFFFF80);
        bus_if.biu_rsp_valid = 1'b0;
        bus_if.ready_out     = 1'b1;
        cyc();
        check("lb_popped", 32'(bus_if.valid_out), 32'd0);

        // ---------------- unsigned byte at 0x103 ----------------
        push(I_LBU, 32'h103, 32'h0);
        cyc();
        cyc();
        bus_if.biu_rsp_valid = 1'b1;
        bus_if.biu_rsp_rdata = 32'h80000000;
        cyc();
        bus_if.biu_rsp_valid = 1'b0;
        check("lbu_read_data", bus_if.read_data, 32'h00000080);
        cyc();

        // ---------------- signed half at 0x102 ----------------
        push(I_LH, 32'h102, 32'h0);
        cyc();
        check("lh_req_mask", 32'(bus_if.biu_req_wmask), 32'hC);
        cyc();
        bus_if.biu_rsp_valid = 1'b1;
        bus_if.biu_rsp_rdata = 32'h80011234;
        cyc();
        bus_if.biu_rsp_valid = 1'b0;
        check("lh_read_data", bus_if.read_data, 32'hFFFF8001);
        cyc();

        // ---------------- store half at 0x102, bus stalls one cycle ----------------
        bus_if.biu_req_ready = 1'b0;
        push(I_SH, 32'h102, 32'h00001234);
        cyc();
        check("sh_req_mask",  32'(bus_if.biu_req_wmask), 32'hC);
        check("sh_req_wdata", bus_if.biu_req_wdata, 32'h12340000);
        check("sh_req_addr",  bus_if.biu_req_addr, 32'h100);
        check("sh_req_write", 32'(bus_if.biu_req_write), 32'd1);
        cyc();
        check("sh_req_held",       32'(bus_if.biu_req_valid), 32'd1);
        check("sh_req_wdata_held", bus_if.biu_req_wdata, 32'h12340000);
        bus_if.biu_req_ready = 1'b1;
        cyc();
        bus_if.biu_rsp_valid = 1'b1;
        bus_if.biu_rsp_rdata = 32'hFFFFFFFF;
        cyc();
        bus_if.biu_rsp_valid = 1'b0;
        check("sh_valid_out", 32'(bus_if.valid_out), 32'd1);
        check("sh_read_data", bus_if.read_data, 32'h0);
        check("sh_err",       32'(bus_if.o_err), 32'd0);
        cyc();

        // ---------------- non-access head completes without the bus ----------------
        push(I_NOP, 32'h0, 32'h0);
        cyc();
        check("nop_valid_out", 32'(bus_if.valid_out), 32'd1);
        check("nop_no_req",    32'(bus_if.biu_req_valid), 32'd0);
        check("nop_read_data", bus_if.read_data, 32'h0);
        cyc();

        // ---------------- full queue back-pressure (DEPTH=2) ----------------
        bus_if.biu_req_ready  = 1'b0;
        bus_if.valid_in       = 1'b1;
        bus_if.i_lsu_inst_bus = I_LW;
        bus_if.i_mem_addr     = 32'h200;
        cyc();                                   // A pushed
        bus_if.i_mem_addr = 32'h204;
        cyc();                                   // B pushed, queue full, A in REQ
        check("full_ready_in_1", 32'(bus_if.ready_in), 32'd0);
        check("full_req_addr_a", bus_if.biu_req_addr, 32'h200);
        bus_if.i_mem_addr = 32'h208;             // C waits
        cyc();
        check("full_ready_in_2", 32'(bus_if.ready_in), 32'd0);
        bus_if.biu_req_ready = 1'b1;
        cyc();                                   // A in WAIT
        bus_if.biu_rsp_valid = 1'b1;
        bus_if.biu_rsp_rdata = 32'h11111111;
        cyc();                                   // A in DONE
        bus_if.biu_rsp_valid = 1'b0;
        check("full_a_data",     bus_if.read_data, 32'h11111111);
        check("full_ready_in_3", 32'(bus_if.ready_in), 32'd0);
        cyc();                                   // A popped; C is not pushed on this edge
        check("full_ready_in_4", 32'(bus_if.ready_in), 32'd1);
        cyc();                                   // C pushed, B in REQ
        bus_if.valid_in = 1'b0;
        check("full_ready_in_5", 32'(bus_if.ready_in), 32'd0);
        check("full_req_addr_b", bus_if.biu_req_addr, 32'h204);
        cyc();
        bus_if.biu_rsp_valid = 1'b1;
        bus_if.biu_rsp_rdata = 32'h22222222;
        cyc();
        bus_if.biu_rsp_valid = 1'b0;
        check("full_b_data", bus_if.read_data, 32'h22222222);
        cyc();                                   // B popped
        cyc();                                   // C in REQ
        check("full_req_addr_c", bus_if.biu_req_addr, 32'h208);
        cyc();
        bus_if.biu_rsp_valid = 1'b1;
        bus_if.biu_rsp_rdata = 32'h33333333;
        cyc();
        bus_if.biu_rsp_valid = 1'b0;
        check("full_c_data", bus_if.read_data, 32'h33333333);
        cyc();                                   // C popped
        cyc();
        check("full_drained", 32'(bus_if.biu_req_valid), 32'd0);

        // ---------------- timeout (TIMEOUT=4) ----------------
        push(I_LW, 32'h300, 32'h0);
        cyc();                                   // REQ
        cyc();                                   // WAIT, timer 0
        cyc();                                   // timer 1
        cyc();                                   // timer 2
        cyc();                                   // timer 3
        cyc();                                   // timer 4
        check("to_not_yet", 32'(bus_if.valid_out), 32'd0);
        cyc();                                   // DONE
        check("to_valid_out", 32'(bus_if.valid_out), 32'd1);
        check("to_err",       32'(bus_if.o_err), 32'd1);
        check("to_read_data", bus_if.read_data, 32'h0);
        cyc();                                   // popped
        bus_if.biu_rsp_valid = 1'b1;             // late response
        bus_if.biu_rsp_rdata = 32'h0000ABCD;
        cyc();
        check("to_late_rsp_1", 32'(bus_if.valid_out), 32'd0);
        cyc();
        bus_if.biu_rsp_valid = 1'b0;
        check("to_late_rsp_2", 32'(bus_if.valid_out), 32'd0);

        // ---------------- misaligned word load at 0x101 ----------------
        push(I_LW, 32'h101, 32'h0);
        cyc();
`ifdef CORE_LSU_MISALIGN_EXCP_EN
        check("mis_no_req",    32'(bus_if.biu_req_valid), 32'd0);
        check("mis_valid_out", 32'(bus_if.valid_out), 32'd1);
        check("mis_err",       32'(bus_if.o_err), 32'd1);
        check("mis_read_data", bus_if.read_data, 32'h0);
        cyc();
`else
        check("mis_req_valid", 32'(bus_if.biu_req_valid), 32'd1);
        check("mis_req_addr",  bus_if.biu_req_addr, 32'h100);
        check("mis_req_mask",  32'(bus_if.biu_req_wmask), 32'hF);
        cyc();
        bus_if.biu_rsp_valid = 1'b1;
        bus_if.biu_rsp_rdata = 32'hCAFEF00D;
        cyc();
        bus_if.biu_rsp_valid = 1'b0;
        check("mis_read_data", bus_if.read_data, 32'hCAFEF00D);
        check("mis_err",       32'(bus_if.o_err), 32'd0);
        cyc();
`endif

        // ---------------- reset mid-transaction ----------------
        push(I_LW, 32'h400, 32'h0);
        cyc();                                   // REQ
        cyc();                                   // WAIT
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready_in",  32'(bus_if.ready_in), 32'd1);
        check("mid_rst_req_valid", 32'(bus_if.biu_req_valid), 32'd0);
        check("mid_rst_read_data", bus_if.read_data, 32'h0);
        cyc();
        rst_n = 1'b1;
        bus_if.biu_rsp_valid = 1'b1;
        bus_if.biu_rsp_rdata = 32'h55555555;
        cyc();
        check("mid_rst_no_out_1", 32'(bus_if.valid_out), 32'd0);
        check("mid_rst_no_req",   32'(bus_if.biu_req_valid), 32'd0);
        cyc();
        bus_if.biu_rsp_valid = 1'b0;
        check("mid_rst_no_out_2", 32'(bus_if.valid_out), 32'd0);
        check("mid_rst_data",     bus_if.read_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
